// File: rtl/tile_loader.sv
// rtl/tile_loader.sv - Avalon-MM read master that preloads one 16x32-word tile into tile RAM
module tile_loader #(
  parameter int MAX_PENDING = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] addr_in,
  input  logic [15:0] stride_in,
  output logic        busy,
  output logic        done,
  output logic [8:0]  ram_addr_out,
  output logic [31:0] ram_wr_data,
  output logic        ram_wren,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic        master_wait_request,
  input  logic [31:0] master_read_data,
  input  logic        master_read_data_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [6:0] MAX_P = 7'(MAX_PENDING);

  state_e      state_q;
  logic [31:0] curr_addr_q;
  logic [31:0] curr_addr_d;
  logic [15:0] stride_q;
  logic [9:0]  issue_idx_q;
  logic [9:0]  recv_idx_q;
  logic [6:0]  pending_q;
  logic [6:0]  pending_d;
  logic        wr_en_q;
  logic [8:0]  wr_addr_q;
  logic [31:0] wr_data_q;
  logic        done_q;
  logic        accept;
  logic        rsp_ok;

  // Request is offered only while issuing and below the in-flight limit; since
  // pending can only fall while a request is stalled, master_read stays high
  // for the whole stall and the address register does not move.
  assign master_read    = (state_q == S_ISSUE) && (pending_q < MAX_P);
  assign master_address = {curr_addr_q[31:2], 2'b00};
  assign accept         = master_read && !master_wait_request;
  // Responses in IDLE (stale after reset) or with nothing pending are dropped.
  assign rsp_ok         = master_read_data_valid && (state_q != S_IDLE) && (pending_q != 7'd0);

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign ram_wren     = wr_en_q;
  assign ram_addr_out = wr_addr_q;
  assign ram_wr_data  = wr_data_q;

  // Next in-flight count and next request address (row wrap at column 15).
  always_comb begin
    pending_d = pending_q;
    case ({accept, rsp_ok})
      2'b10:   pending_d = pending_q + 7'd1;
      2'b01:   pending_d = pending_q - 7'd1;
      default: pending_d = pending_q;
    endcase
    if (issue_idx_q[3:0] == 4'hF) begin
      curr_addr_d = curr_addr_q + {16'h0000, stride_q} - 32'd60;
    end else begin
      curr_addr_d = curr_addr_q + 32'd4;
    end
  end

  // Control FSM, request counters and the one-cycle response-to-RAM register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      curr_addr_q <= 32'd0;
      stride_q    <= 16'd0;
      issue_idx_q <= 10'd0;
      recv_idx_q  <= 10'd0;
      pending_q   <= 7'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 9'd0;
      wr_data_q   <= 32'd0;
      done_q      <= 1'b0;
    end else begin
      wr_en_q   <= rsp_ok;
      done_q    <= rsp_ok && (recv_idx_q == 10'd511);
      pending_q <= pending_d;
      if (rsp_ok) begin
        wr_addr_q  <= recv_idx_q[8:0];
        wr_data_q  <= master_read_data;
        recv_idx_q <= recv_idx_q + 10'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            curr_addr_q <= addr_in;
            stride_q    <= stride_in;
            issue_idx_q <= 10'd0;
            recv_idx_q  <= 10'd0;
            pending_q   <= 7'd0;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (accept) begin
            curr_addr_q <= curr_addr_d;
            issue_idx_q <= issue_idx_q + 10'd1;
            if (issue_idx_q == 10'd511) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (done_q) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_loader.sv
// tb/tb_tile_loader.sv - scoreboard bench for tile_loader
module tb_tile_loader;
  localparam int MAXP = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] addr_in = 32'd0;
  logic [15:0] stride_in = 16'd0;
  logic        busy, done, ram_wren, master_read;
  logic [8:0]  ram_addr_out;
  logic [31:0] ram_wr_data, master_address;
  logic        wait_r = 1'b0;
  logic [31:0] rd_data = 32'd0;
  logic        rd_valid = 1'b0;

  tile_loader #(.MAX_PENDING(MAXP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr_in(addr_in), .stride_in(stride_in),
    .busy(busy), .done(done), .ram_addr_out(ram_addr_out), .ram_wr_data(ram_wr_data),
    .ram_wren(ram_wren), .master_address(master_address), .master_read(master_read),
    .master_wait_request(wait_r), .master_read_data(rd_data),
    .master_read_data_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory / scoreboard model state
  bit          tb_active = 1'b0;
  bit          force_valid = 1'b0;
  logic [31:0] tb_base = 32'd0;
  logic [31:0] tb_seed = 32'd0;
  logic [15:0] tb_stride = 16'd0;
  logic [31:0] last_acc_addr = 32'd0;
  logic [31:0] addr16 = 32'd0;
  int acc_count = 0, rsp_issued = 0, wr_count = 0, done_cnt = 0, done_cyc = 0;
  int out_n = 0, max_out = 0, coincide_cnt = 0, start_cyc = 0;
  int lat = 3, wait_pct = 0, gap_pct = 0;
  int stall_at = -1, stall_len = 0, stall_cnt = 0, stall_obs = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  typedef struct { logic [31:0] a; int due; } req_t;
  typedef struct { logic [8:0] a; logic [31:0] d; } wr_t;
  req_t rq[$];
  wr_t  sb[$];

  function automatic logic [31:0] exp_addr(input int idx);
    return tb_base + 32'(idx / 16) * {16'h0000, tb_stride} + 32'(idx % 16) * 32'd4;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ tb_seed;
  endfunction

  // Avalon slave: wait_request generation and in-order read responses
  initial begin
    forever begin
      @(posedge clk);
      #1;
      wait_r = 1'b0;
      if (tb_active && stall_at >= 0 && acc_count == stall_at && stall_cnt < stall_len) begin
        wait_r = 1'b1;
        stall_cnt++;
      end else if (wait_pct > 0 && $urandom_range(99) < wait_pct) begin
        wait_r = 1'b1;
      end
      rd_valid = 1'b0;
      if (force_valid) begin
        rd_valid = 1'b1;
        rd_data  = 32'hDEADBEEF;
      end else if (tb_active && rq.size() > 0 && rq[0].due <= cyc &&
                   !(gap_pct > 0 && $urandom_range(99) < gap_pct)) begin
        rd_valid = 1'b1;
        rd_data  = mem_word(rq[0].a);
        sb.push_back('{a: 9'(rsp_issued), d: rd_data});
        rsp_issued++;
        void'(rq.pop_front());
      end
    end
  end

  // Monitor: request ordering, pending bound, stall stability, RAM scoreboard, done
  initial begin
    logic acc, vld;
    wr_t w;
    forever begin
      @(negedge clk);
      acc = master_read && !wait_r;
      vld = rd_valid && tb_active;
      if (tb_active) begin
        if (master_read && out_n >= MAXP) begin
          errors++;
          $display("FAIL pending_bound: master_read=%b with outstanding=%0d limit %0d", master_read, out_n, MAXP);
        end
        if (prev_stall) begin
          checks++;
          if (master_read !== 1'b1 || master_address !== prev_addr) begin
            errors++;
            $display("FAIL stall_stable: read=%b addr=%h expected read=1 addr=%h", master_read, master_address, prev_addr);
          end
        end
        if (wait_r && stall_at >= 0 && acc_count == stall_at) begin
          checks++;
          stall_obs++;
          if (master_read !== 1'b1 || master_address !== exp_addr(stall_at)) begin
            errors++;
            $display("FAIL stall_req: read=%b addr=%h expected read=1 addr=%h", master_read, master_address, exp_addr(stall_at));
          end
        end
        if (acc) begin
          checks++;
          if (acc_count >= 512 || master_address !== exp_addr(acc_count)) begin
            errors++;
            $display("FAIL req_addr: idx %0d got %h expected %h", acc_count, master_address, exp_addr(acc_count));
          end
          rq.push_back('{a: master_address, due: cyc + lat});
          last_acc_addr = master_address;
          if (acc_count == 16) addr16 = master_address;
          acc_count++;
        end
        if (acc && vld) coincide_cnt++;
        out_n = out_n + (acc ? 1 : 0) - (vld ? 1 : 0);
        if (out_n > max_out) max_out = out_n;
      end
      prev_stall = master_read && wait_r;
      prev_addr  = master_address;
      if (ram_wren !== 1'b0) begin
        checks++;
        wr_count++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL ram_unexpected: wren=%b addr=%0d data=%h expected no write", ram_wren, ram_addr_out, ram_wr_data);
        end else begin
          w = sb.pop_front();
          if (ram_addr_out !== w.a || ram_wr_data !== w.d) begin
            errors++;
            $display("FAIL ram_write: got addr=%0d data=%h expected addr=%0d data=%h", ram_addr_out, ram_wr_data, w.a, w.d);
          end
        end
      end
      if (done !== 1'b0) begin
        checks++;
        done_cnt++;
        done_cyc = cyc;
        if (ram_wren !== 1'b1 || ram_addr_out !== 9'd511) begin
          errors++;
          $display("FAIL done_word: wren=%b addr=%0d expected wren=1 addr=511", ram_wren, ram_addr_out);
        end
      end
    end
  end

  task automatic begin_tile(input logic [31:0] base, input logic [15:0] stride, input int l, input logic [31:0] seed);
    @(posedge clk);
    #2;
    tb_base = base; tb_stride = stride; tb_seed = seed; lat = l;
    acc_count = 0; rsp_issued = 0; wr_count = 0; out_n = 0; max_out = 0;
    coincide_cnt = 0; stall_cnt = 0; stall_obs = 0;
    rq.delete(); sb.delete();
    tb_active = 1'b1;
    addr_in = base; stride_in = stride; start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle: got %b expected 0", busy);
    end
    @(posedge clk);
    #2;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_run: got %b expected 1", busy);
    end
  endtask

  task automatic finish_tile(input bit check_lat);
    int d0, t;
    d0 = done_cnt - ((done_cyc >= start_cyc && done_cnt > 0) ? 1 : 0);
    t = 0;
    while (done_cnt == d0 && t < 20000) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles", t);
    end
    checks++;
    if (acc_count != 512 || wr_count != 512 || sb.size() != 0) begin
      errors++;
      $display("FAIL tile_count: accepts=%0d writes=%0d left=%0d expected 512 512 0", acc_count, wr_count, sb.size());
    end
    if (check_lat) begin
      checks++;
      if (done_cyc - start_cyc != 513 + lat) begin
        errors++;
        $display("FAIL tile_latency: got %0d cycles expected %0d", done_cyc - start_cyc, 513 + lat);
      end
    end
  endtask

  task automatic run_tile(input logic [31:0] base, input logic [15:0] stride, input int l,
                          input logic [31:0] seed, input bit check_lat);
    begin_tile(base, stride, l, seed);
    finish_tile(check_lat);
  endtask

  task automatic check_idle();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_done: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ram_wren !== 1'b0 || master_read !== 1'b0 ||
        master_address !== 32'd0 || ram_addr_out !== 9'd0 || ram_wr_data !== 32'd0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b wren=%b rd=%b addr=%h raddr=%0d rdata=%h expected all 0",
               tag, busy, done, ram_wren, master_read, master_address, ram_addr_out, ram_wr_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_state");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("after_release");
  endtask

  task automatic test_basic();
    wait_pct = 0; gap_pct = 0; stall_at = -1;
    run_tile(32'h0000_1000, 16'h0400, 3, 32'h1111_0000, 1'b1);
    checks++;
    if (last_acc_addr !== 32'h0000_8C3C || addr16 !== 32'h0000_1400) begin
      errors++;
      $display("FAIL basic_addrs: last=%h row1=%h expected 00008c3c 00001400", last_acc_addr, addr16);
    end
    check_idle();
  endtask

  task automatic test_stall();
    stall_at = 7; stall_len = 5;
    run_tile(32'h0000_1000, 16'h0400, 3, 32'h2222_0000, 1'b0);
    checks++;
    if (stall_obs != 5) begin
      errors++;
      $display("FAIL stall_cycles: got %0d expected 5", stall_obs);
    end
    stall_at = -1;
    check_idle();
  endtask

  task automatic test_pending();
    run_tile(32'h0002_0000, 16'h0100, 20, 32'h3333_0000, 1'b0);
    checks++;
    if (max_out != MAXP || coincide_cnt == 0) begin
      errors++;
      $display("FAIL pending_limit: max_out=%0d coincide=%0d expected %0d and >0", max_out, coincide_cnt, MAXP);
    end
    check_idle();
  endtask

  task automatic test_wrap();
    run_tile(32'hFFFF_FFC0, 16'h0040, 2, 32'h4444_0000, 1'b0);
    checks++;
    if (addr16 !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_addr: got %h expected 00000000", addr16);
    end
    check_idle();
  endtask

  task automatic test_reset_midload();
    int t, d0, w0;
    begin_tile(32'h0003_0000, 16'h0200, 3, 32'h5555_0000);
    t = 0;
    while (wr_count < 50 && t < 5000) begin @(negedge clk); #1; t++; end
    @(posedge clk); #2;
    addr_in = 32'hBAD0_0000; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    t = 0;
    while (wr_count < 200 && t < 5000) begin @(negedge clk); #1; t++; end
    checks++;
    if (wr_count < 200 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midload_progress: writes=%0d busy=%b expected >=200 and 1", wr_count, busy);
    end
    d0 = done_cnt;
    @(posedge clk); #2;
    rst_n = 1'b0;
    tb_active = 1'b0;
    rq.delete(); sb.delete();
    @(negedge clk);
    check_outputs_zero("midload_reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("post_reset");
    w0 = wr_count;
    force_valid = 1'b1;
    @(negedge clk);
    force_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (wr_count != w0 || done_cnt != d0) begin
      errors++;
      $display("FAIL stray_valid: writes=%0d dones=%0d expected %0d %0d", wr_count, done_cnt, w0, d0);
    end
    run_tile(32'h0004_0000, 16'h0080, 3, 32'h6666_0000, 1'b1);
    check_idle();
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    wait_pct = 30; gap_pct = 30;
    run_tile(32'h0005_0000, 16'h0400, 4, 32'h7777_0000, 1'b0);
    run_tile(32'h0006_0004, 16'h0100, 2, 32'h8888_0000, 1'b0);
    run_tile(32'hFFFF_F000, 16'h1000, 5, 32'h9999_0000, 1'b0);
    wait_pct = 0; gap_pct = 0;
    check_idle();
    checks++;
    if (done_cnt - d0 != 3) begin
      errors++;
      $display("FAIL b2b_dones: got %0d expected 3", done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_pending();
    test_wrap();
    test_reset_midload();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
